// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares the single L2/main-memory port between the
// instruction cache (requester 0, "i") and the data cache (requester 1, "d").
// One line-sized transaction is in flight at a time. Ties are broken
// round-robin, the grant is held until memory answers, and only the winner
// sees the ready pulse. Grant and conflict counters feed performance reporting.
module l1_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 128,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              i_req_valid_i,
   input  logic              i_req_rw_i,
   input  logic [ADDR_W-1:0] i_req_addr_i,
   input  logic [LINE_W-1:0] i_req_data_i,
   output logic              i_res_ready_o,
   output logic [LINE_W-1:0] i_res_data_o,
   input  logic              d_req_valid_i,
   input  logic              d_req_rw_i,
   input  logic [ADDR_W-1:0] d_req_addr_i,
   input  logic [LINE_W-1:0] d_req_data_i,
   output logic              d_res_ready_o,
   output logic [LINE_W-1:0] d_res_data_o,
   output logic              mem_valid_o,
   output logic              mem_rw_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic              mem_ready_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic [CNT_W-1:0]  no_grant_i_o,
   output logic [CNT_W-1:0]  no_grant_d_o,
   output logic [CNT_W-1:0]  no_conflict_o
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e             state_q, state_d;
   logic               gnt_id_q, gnt_id_d;         // 0 = icache, 1 = dcache
   logic               last_grant_q, last_grant_d; // requester served last
   logic               mem_valid_q, mem_valid_d;
   logic               mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]  mem_data_q, mem_data_d;
   logic [CNT_W-1:0]   cnt_gnt_i_q, cnt_gnt_i_d;
   logic [CNT_W-1:0]   cnt_gnt_d_q, cnt_gnt_d_d;
   logic [CNT_W-1:0]   cnt_conf_q, cnt_conf_d;

   logic               both_valid_s;
   logic               any_valid_s;
   logic               pick_d_s;
   logic               done_s;

   // Arbitration decision: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      both_valid_s = i_req_valid_i & d_req_valid_i;
      any_valid_s  = i_req_valid_i | d_req_valid_i;
      if (both_valid_s) begin
         pick_d_s = ~last_grant_q;
      end else begin
         pick_d_s = d_req_valid_i;
      end
      done_s = (state_q == BUSY) & mem_ready_i;
   end

   // Next-state logic: launch a transaction from IDLE, retire it on mem_ready_i in BUSY.
   always_comb begin
      state_d      = state_q;
      gnt_id_d     = gnt_id_q;
      last_grant_d = last_grant_q;
      mem_valid_d  = mem_valid_q;
      mem_rw_d     = mem_rw_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      cnt_gnt_i_d  = cnt_gnt_i_q;
      cnt_gnt_d_d  = cnt_gnt_d_q;
      cnt_conf_d   = cnt_conf_q;
      case (state_q)
         IDLE: begin
            if (both_valid_s) begin
               cnt_conf_d = cnt_conf_q + CNT_ONE;
            end else begin
               cnt_conf_d = cnt_conf_q;
            end
            if (any_valid_s) begin
               state_d     = BUSY;
               mem_valid_d = 1'b1;
               gnt_id_d    = pick_d_s;
               if (pick_d_s) begin
                  mem_rw_d    = d_req_rw_i;
                  mem_addr_d  = d_req_addr_i;
                  mem_data_d  = d_req_data_i;
                  cnt_gnt_d_d = cnt_gnt_d_q + CNT_ONE;
               end else begin
                  mem_rw_d    = i_req_rw_i;
                  mem_addr_d  = i_req_addr_i;
                  mem_data_d  = i_req_data_i;
                  cnt_gnt_i_d = cnt_gnt_i_q + CNT_ONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // Requester inputs are deliberately ignored until memory answers.
            if (mem_ready_i) begin
               state_d      = IDLE;
               mem_valid_d  = 1'b0;
               last_grant_d = gnt_id_q;
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
         end
      endcase
   end

   // State, captured request and statistics registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         gnt_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
         mem_valid_q  <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         cnt_gnt_i_q  <= '0;
         cnt_gnt_d_q  <= '0;
         cnt_conf_q   <= '0;
      end else begin
         state_q      <= state_d;
         gnt_id_q     <= gnt_id_d;
         last_grant_q <= last_grant_d;
         mem_valid_q  <= mem_valid_d;
         mem_rw_q     <= mem_rw_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         cnt_gnt_i_q  <= cnt_gnt_i_d;
         cnt_gnt_d_q  <= cnt_gnt_d_d;
         cnt_conf_q   <= cnt_conf_d;
      end
   end

   // Ready is steered to the granted requester only; read data is broadcast.
   always_comb begin
      i_res_ready_o = done_s & ~gnt_id_q;
      d_res_ready_o = done_s & gnt_id_q;
      i_res_data_o  = mem_data_i;
      d_res_data_o  = mem_data_i;
   end

   assign mem_valid_o   = mem_valid_q;
   assign mem_rw_o      = mem_rw_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_data_o    = mem_data_q;
   assign no_grant_i_o  = cnt_gnt_i_q;
   assign no_grant_d_o  = cnt_gnt_d_q;
   assign no_conflict_o = cnt_conf_q;

endmodule
